// File: rtl/phaser_out_tap_ctrl.sv
// Command sequencer for one PHASER_OUT: issues single-cycle fine/coarse step,
// counter load and counter read pulses, tracks tap positions and aborts on range or overflow.
module phaser_out_tap_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int READ_LAT      = 3,
    parameter int FINE_MAX      = 63,
    parameter int COARSE_MAX    = 7
) (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic       CMD_INC,
    input  logic [5:0] CMD_COUNT,
    input  logic [8:0] CMD_LOADVAL,
    output logic       DONE,
    output logic       ERR,
    output logic [8:0] RSP_DATA,
    output logic [5:0] FINE_TAP,
    output logic [2:0] COARSE_TAP,
    output logic       FINEENABLE,
    output logic       FINEINC,
    output logic       COARSEENABLE,
    output logic       COARSEINC,
    output logic       COUNTERLOADEN,
    output logic [8:0] COUNTERLOADVAL,
    output logic       COUNTERREADEN,
    input  logic [8:0] COUNTERREADVAL,
    input  logic       FINEOVERFLOW,
    input  logic       COARSEOVERFLOW
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PULSE   = 3'd2,
        SETTLE  = 3'd3,
        RD_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [1:0] OP_FINE   = 2'b00;
    localparam logic [1:0] OP_COARSE = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] READ_LOAD   = 4'(READ_LAT - 1);
    localparam logic [5:0] FINE_TOP    = 6'(FINE_MAX);
    localparam logic [2:0] COARSE_TOP  = 3'(COARSE_MAX);

    state_t     state, next_state;
    logic [1:0] op_q;
    logic       inc_q;
    logic [5:0] count_q;
    logic [8:0] loadval_q;
    logic [7:0] settle_cnt;
    logic [3:0] rd_cnt;
    logic       err_q, next_err;

    logic fine_lim, coarse_lim, at_limit, ovf_hit, in_pulse;

    assign fine_lim   = inc_q ? (FINE_TAP == FINE_TOP)     : (FINE_TAP == 6'd0);
    assign coarse_lim = inc_q ? (COARSE_TAP == COARSE_TOP) : (COARSE_TAP == 3'd0);
    assign at_limit   = (op_q == OP_FINE) ? fine_lim : coarse_lim;
    // Only the overflow flag belonging to the line just stepped can abort.
    assign ovf_hit    = ((op_q == OP_FINE) && FINEOVERFLOW) ||
                        ((op_q == OP_COARSE) && COARSEOVERFLOW);
    assign in_pulse   = (state == PULSE);

    assign CMD_READY      = (state == IDLE);
    assign DONE           = (state == FINISH);
    assign ERR            = DONE && err_q;
    assign FINEENABLE     = in_pulse && (op_q == OP_FINE);
    assign FINEINC        = FINEENABLE && inc_q;
    assign COARSEENABLE   = in_pulse && (op_q == OP_COARSE);
    assign COARSEINC      = COARSEENABLE && inc_q;
    assign COUNTERLOADEN  = in_pulse && (op_q == OP_LOAD);
    assign COUNTERLOADVAL = COUNTERLOADEN ? loadval_q : 9'd0;
    assign COUNTERREADEN  = in_pulse && (op_q == OP_READ);

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= next_err;
        end
    end

    always_comb begin
        next_state = state;
        next_err   = err_q;
        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    next_err   = 1'b0;
                    next_state = CMD_OP[1] ? PULSE : CHECK;
                end
            end
            CHECK: begin
                if (count_q == 6'd0) begin
                    next_err   = 1'b0;
                    next_state = FINISH;
                end else if (at_limit) begin
                    next_err   = 1'b1;
                    next_state = FINISH;
                end else begin
                    next_state = PULSE;
                end
            end
            PULSE: next_state = (op_q == OP_READ) ? RD_WAIT : SETTLE;
            SETTLE: begin
                if (ovf_hit) begin
                    next_err   = 1'b1;
                    next_state = FINISH;
                end else if (settle_cnt == 8'd0) begin
                    next_err   = 1'b0;
                    next_state = (op_q == OP_LOAD) ? FINISH : CHECK;
                end
            end
            RD_WAIT: begin
                if (rd_cnt == 4'd0) begin
                    next_err   = 1'b0;
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command latch, tap tracking and settle/read-latency counters.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            op_q       <= OP_FINE;
            inc_q      <= 1'b0;
            count_q    <= 6'd0;
            loadval_q  <= 9'd0;
            settle_cnt <= 8'd0;
            rd_cnt     <= 4'd0;
            RSP_DATA   <= 9'd0;
            FINE_TAP   <= 6'd0;
            COARSE_TAP <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        op_q      <= CMD_OP;
                        inc_q     <= CMD_INC;
                        count_q   <= CMD_COUNT;
                        loadval_q <= CMD_LOADVAL;
                    end
                end
                PULSE: begin
                    settle_cnt <= SETTLE_LOAD;
                    rd_cnt     <= READ_LOAD;
                    case (op_q)
                        OP_FINE: begin
                            FINE_TAP <= inc_q ? FINE_TAP + 6'd1 : FINE_TAP - 6'd1;
                            count_q  <= count_q - 6'd1;
                        end
                        OP_COARSE: begin
                            COARSE_TAP <= inc_q ? COARSE_TAP + 3'd1 : COARSE_TAP - 3'd1;
                            count_q    <= count_q - 6'd1;
                        end
                        OP_LOAD: FINE_TAP <= loadval_q[5:0];
                        default: ;
                    endcase
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0)
                        settle_cnt <= settle_cnt - 8'd1;
                end
                RD_WAIT: begin
                    if (rd_cnt == 4'd0)
                        RSP_DATA <= COUNTERREADVAL;
                    else
                        rd_cnt <= rd_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// Directed self-checking bench for phaser_out_tap_ctrl (SETTLE_CYCLES=8, READ_LAT=3).
module tb_phaser_out_tap_ctrl;

    logic       SYSCLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic       CMD_INC;
    logic [5:0] CMD_COUNT;
    logic [8:0] CMD_LOADVAL;
    logic       DONE, ERR;
    logic [8:0] RSP_DATA;
    logic [5:0] FINE_TAP;
    logic [2:0] COARSE_TAP;
    logic       FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
    logic       COUNTERLOADEN, COUNTERREADEN;
    logic [8:0] COUNTERLOADVAL, COUNTERREADVAL;
    logic       FINEOVERFLOW, COARSEOVERFLOW;

    phaser_out_tap_ctrl #(.SETTLE_CYCLES(8), .READ_LAT(3), .FINE_MAX(63), .COARSE_MAX(7)) dut (
        .SYSCLK(SYSCLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_INC(CMD_INC),
        .CMD_COUNT(CMD_COUNT), .CMD_LOADVAL(CMD_LOADVAL),
        .DONE(DONE), .ERR(ERR), .RSP_DATA(RSP_DATA), .FINE_TAP(FINE_TAP), .COARSE_TAP(COARSE_TAP),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC), .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL),
        .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ovf_fine_k = -1;
    int ovf_coarse_k = -1;
    bit ramp_rv = 1'b0;

    int fine_n, fine_inc_n, first_fine, last_fine, min_fine_gap;
    int coarse_n, coarse_inc_n, load_n, read_n, done_n, done_cyc;
    logic err_at_done;
    logic [8:0] lv_seen;
    int bad_inc = 0, bad_lv = 0, bad_err = 0, bad_width = 0;
    logic prev_fe = 1'b0, prev_ce = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic clearMon();
        fine_n = 0; fine_inc_n = 0; first_fine = -1; last_fine = -1; min_fine_gap = 1000;
        coarse_n = 0; coarse_inc_n = 0; load_n = 0; read_n = 0; done_n = 0; done_cyc = -1;
        err_at_done = 1'b0; lv_seen = 9'd0;
    endtask

    // One clock: observe outputs 1 time unit after the edge, then drive time-indexed inputs.
    task automatic tick();
        int k;
        @(posedge SYSCLK);
        #1;
        cyc++;
        k = cyc - acc_cyc;
        if (FINEENABLE) begin
            fine_n++;
            if (FINEINC) fine_inc_n++;
            if (prev_fe) bad_width++;
            if (first_fine < 0) first_fine = cyc;
            if (last_fine >= 0 && (cyc - last_fine) < min_fine_gap) min_fine_gap = cyc - last_fine;
            last_fine = cyc;
        end
        if (COARSEENABLE) begin
            coarse_n++;
            if (COARSEINC) coarse_inc_n++;
            if (prev_ce) bad_width++;
        end
        prev_fe = FINEENABLE;
        prev_ce = COARSEENABLE;
        if ((FINEINC && !FINEENABLE) || (COARSEINC && !COARSEENABLE)) bad_inc++;
        if (COUNTERLOADEN) begin
            load_n++;
            lv_seen = COUNTERLOADVAL;
        end else if (COUNTERLOADVAL != 9'd0) bad_lv++;
        if (COUNTERREADEN) read_n++;
        if (ERR && !DONE) bad_err++;
        if (DONE) begin
            done_n++;
            done_cyc = cyc;
            err_at_done = ERR;
        end
        if (ramp_rv) COUNTERREADVAL = 9'h100 | 9'(k);
        FINEOVERFLOW   = (k == ovf_fine_k);
        COARSEOVERFLOW = (k == ovf_coarse_k);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic inc, input logic [5:0] count,
                                 input logic [8:0] loadval, input int ovf_f, input int ovf_c);
        checkOutput("ready_before_accept", CMD_READY, 1);
        clearMon();
        ovf_fine_k   = ovf_f;
        ovf_coarse_k = ovf_c;
        CMD_OP = op; CMD_INC = inc; CMD_COUNT = count; CMD_LOADVAL = loadval;
        CMD_VALID = 1'b1;
        acc_cyc = cyc;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_n > 0) break;
            tick();
        end
        checkOutput({tag, "_done_seen"}, done_n, 1);
        ovf_fine_k = -1;
        ovf_coarse_k = -1;
        tick();
        checkOutput({tag, "_ready_after_done"}, CMD_READY, 1);
        checkOutput({tag, "_single_done"}, done_n, 1);
    endtask

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_INC = 1'b0; CMD_COUNT = 6'd0;
        CMD_LOADVAL = 9'd0; COUNTERREADVAL = 9'd0; FINEOVERFLOW = 1'b0; COARSEOVERFLOW = 1'b0;
        clearMon();
        repeat (3) tick();
        checkOutput("rst_ready", CMD_READY, 1);
        checkOutput("rst_done", DONE, 0);
        checkOutput("rst_fine_tap", FINE_TAP, 0);
        checkOutput("rst_coarse_tap", COARSE_TAP, 0);
        checkOutput("rst_rsp", RSP_DATA, 0);
        checkOutput("rst_enables", {FINEENABLE, COARSEENABLE, COUNTERLOADEN, COUNTERREADEN}, 0);
        RST = 1'b0;
        tick();

        $display("[TB] fine inc x3, stray overflow outside SETTLE and on the other line");
        applyStimulus(2'b00, 1'b1, 6'd3, 9'd0, 1, 5);
        waitDone("fine3", 100);
        checkOutput("fine3_pulses", fine_n, 3);
        checkOutput("fine3_inc_pulses", fine_inc_n, 3);
        checkOutput("fine3_min_gap", min_fine_gap, 10);
        checkOutput("fine3_span", last_fine - first_fine, 20);
        checkOutput("fine3_tap", FINE_TAP, 3);
        checkOutput("fine3_err", err_at_done, 0);
        checkOutput("fine3_latency", done_cyc - acc_cyc, 32);

        $display("[TB] load 62 then fine inc x4 hits the top tap");
        applyStimulus(2'b10, 1'b0, 6'd0, 9'd62, -1, -1);
        waitDone("load62", 100);
        checkOutput("load62_latency", done_cyc - acc_cyc, 10);
        checkOutput("load62_tap", FINE_TAP, 62);
        applyStimulus(2'b00, 1'b1, 6'd4, 9'd0, -1, -1);
        waitDone("fine_top", 100);
        checkOutput("fine_top_pulses", fine_n, 1);
        checkOutput("fine_top_tap", FINE_TAP, 63);
        checkOutput("fine_top_err", err_at_done, 1);
        checkOutput("fine_top_latency", done_cyc - acc_cyc, 12);

        $display("[TB] coarse dec at tap 0");
        applyStimulus(2'b01, 1'b0, 6'd2, 9'd0, -1, -1);
        waitDone("coarse_floor", 100);
        checkOutput("coarse_floor_pulses", coarse_n, 0);
        checkOutput("coarse_floor_err", err_at_done, 1);
        checkOutput("coarse_floor_latency", done_cyc - acc_cyc, 2);

        $display("[TB] counter load 0x02A and read back");
        applyStimulus(2'b10, 1'b0, 6'd0, 9'h02A, -1, -1);
        waitDone("load2a", 100);
        checkOutput("load2a_pulses", load_n, 1);
        checkOutput("load2a_value", lv_seen, 9'h02A);
        checkOutput("load2a_tap", FINE_TAP, 42);
        COUNTERREADVAL = 9'h02A;
        applyStimulus(2'b11, 1'b0, 6'd0, 9'd0, -1, -1);
        waitDone("read2a", 100);
        checkOutput("read2a_pulses", read_n, 1);
        checkOutput("read2a_rsp", RSP_DATA, 9'h02A);
        checkOutput("read2a_err", err_at_done, 0);
        checkOutput("read2a_latency", done_cyc - acc_cyc, 5);

        // Read value changes every cycle; the capture edge is 4 cycles after accept.
        ramp_rv = 1'b1;
        applyStimulus(2'b11, 1'b0, 6'd0, 9'd0, -1, -1);
        waitDone("read_ramp", 100);
        ramp_rv = 1'b0;
        checkOutput("read_ramp_rsp", RSP_DATA, 9'h104);

        $display("[TB] coarse inc x5 with overflow in the second settle");
        applyStimulus(2'b01, 1'b1, 6'd5, 9'd0, -1, 15);
        waitDone("coarse_ovf", 100);
        checkOutput("coarse_ovf_pulses", coarse_n, 2);
        checkOutput("coarse_ovf_inc_pulses", coarse_inc_n, 2);
        checkOutput("coarse_ovf_tap", COARSE_TAP, 2);
        checkOutput("coarse_ovf_err", err_at_done, 1);
        checkOutput("coarse_ovf_latency", done_cyc - acc_cyc, 16);

        $display("[TB] reset in the middle of a 10-step fine command");
        applyStimulus(2'b00, 1'b1, 6'd10, 9'd0, -1, -1);
        repeat (3) tick();
        checkOutput("pre_rst_tap", FINE_TAP, 43);
        #2;
        CMD_OP = 2'b00; CMD_INC = 1'b1; CMD_COUNT = 6'd1; CMD_VALID = 1'b1;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_tap", FINE_TAP, 0);
        checkOutput("async_rst_coarse", COARSE_TAP, 0);
        checkOutput("async_rst_rsp", RSP_DATA, 0);
        checkOutput("async_rst_ready", CMD_READY, 1);
        clearMon();
        repeat (2) tick();
        RST = 1'b0;
        checkOutput("rst_no_done", done_n, 0);
        acc_cyc = cyc;
        tick();
        checkOutput("post_rst_accepted", CMD_READY, 0);
        CMD_VALID = 1'b0;
        waitDone("post_rst", 100);
        checkOutput("post_rst_pulses", fine_n, 1);
        checkOutput("post_rst_tap", FINE_TAP, 1);
        checkOutput("post_rst_err", err_at_done, 0);
        checkOutput("post_rst_latency", done_cyc - acc_cyc, 12);

        checkOutput("inc_without_enable", bad_inc, 0);
        checkOutput("loadval_outside_pulse", bad_lv, 0);
        checkOutput("err_without_done", bad_err, 0);
        checkOutput("enable_width", bad_width, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/phaser_out_tap_ctrl.md
Name: phaser_out_tap_ctrl

Overview:
Command-driven sequencer for one PHASER_OUT instance: steps the fine and coarse delay lines, loads the counter and reads it back.
- Runs on the same SYSCLK domain as PHASER_OUT.
- Sits between calibration logic and the phaser.
- Guarantees single-cycle enable pulses, settle spacing between steps, tap-range tracking and overflow abort.

Parameters:
SETTLE_CYCLES, 8, idle SYSCLK cycles after each enable/load pulse before the next action (legal 1..255)
READ_LAT, 3, SYSCLK cycles from COUNTERREADEN pulse to COUNTERREADVAL capture (legal 1..15)
FINE_MAX, 63, highest legal fine tap
COARSE_MAX, 7, highest legal coarse tap

Ports:
SYSCLK  in  1  clock, shared with PHASER_OUT SYSCLK
RST  in  1  asynchronous active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  controller can accept a command
CMD_OP  in  2  00 fine step, 01 coarse step, 10 counter load, 11 counter read
CMD_INC  in  1  1 = increment, 0 = decrement (step ops only)
CMD_COUNT  in  6  number of steps (step ops only)
CMD_LOADVAL  in  9  counter load value (load op only)
DONE  out  1  one-cycle pulse at command completion
ERR  out  1  valid with DONE; 1 = aborted (range or overflow)
RSP_DATA  out  9  captured COUNTERREADVAL; holds until the next read completes
FINE_TAP  out  6  tracked fine tap position
COARSE_TAP  out  3  tracked coarse tap position
FINEENABLE, FINEINC, COARSEENABLE, COARSEINC  out  1 each  to PHASER_OUT
COUNTERLOADEN  out  1  to PHASER_OUT
COUNTERLOADVAL  out  9  to PHASER_OUT
COUNTERREADEN  out  1  to PHASER_OUT
COUNTERREADVAL  in  9  from PHASER_OUT
FINEOVERFLOW, COARSEOVERFLOW  in  1 each  from PHASER_OUT

Behaviour:
- Reset (async assert, sync release): state IDLE; CMD_READY=1; all other outputs 0, including RSP_DATA, FINE_TAP and COARSE_TAP.
- RST asserted mid-command: abort immediately, return to reset values, no DONE.
- States: IDLE, CHECK, PULSE, SETTLE, RD_WAIT, FINISH.
- Handshake and IDLE:
  - CMD_READY=1 only in IDLE.
  - Accept on CMD_VALID & CMD_READY; latch op, inc, count and loadval.
  - IDLE -> CHECK for step ops; IDLE -> PULSE for load and read.
- CHECK (step ops):
  - Remaining count 0 -> FINISH with ERR=0. CMD_COUNT=0 therefore produces no pulses.
  - Tracked tap at its limit in the requested direction (inc at FINE_MAX/COARSE_MAX, dec at 0) -> FINISH with ERR=1, no pulse.
  - Otherwise -> PULSE.
- PULSE (exactly one cycle):
  - Fine step: FINEENABLE=1, FINEINC=inc.
  - Coarse step: COARSEENABLE=1, COARSEINC=inc.
  - Load: COUNTERLOADEN=1, COUNTERLOADVAL=loadval; FINE_TAP <= loadval[5:0].
  - Read: COUNTERREADEN=1.
  - Step ops update the tracked tap by ±1 and decrement remaining count.
  - Next state: read -> RD_WAIT; all others -> SETTLE.
- INC outputs: FINEINC/COARSEINC are 0 whenever the matching ENABLE is 0. COUNTERLOADVAL is 0 outside its pulse.
- SETTLE:
  - Lasts SETTLE_CYCLES cycles.
  - If the overflow input matching the current op (FINEOVERFLOW or COARSEOVERFLOW) samples 1 on any cycle: exit at the end of that cycle to FINISH with ERR=1. The tracked tap keeps its post-step value.
  - On timeout: step ops -> CHECK; load -> FINISH with ERR=0.
- RD_WAIT:
  - Counts READ_LAT cycles.
  - On the last cycle, RSP_DATA <= COUNTERREADVAL.
  - -> FINISH with ERR=0.
- FINISH (one cycle): DONE=1, ERR as determined -> IDLE. ERR is 0 whenever DONE=0.
- Enable spacing: two enables for the same line are always at least SETTLE_CYCLES+1 cycles apart.
- Read latency: accept to DONE is 1 + READ_LAT + 1 cycles.
- Overflow inputs are ignored outside SETTLE.

Test Plan:
- Reset then fine step, inc, CMD_COUNT=3 -> 3 single-cycle FINEENABLE pulses with FINEINC=1, spaced 9 cycles apart (SETTLE_CYCLES=8); FINE_TAP=3; DONE=1, ERR=0; CMD_READY returns 1 the cycle after DONE.
- FINE_TAP=62, fine inc with CMD_COUNT=4 -> one pulse, FINE_TAP=63, then DONE with ERR=1; no further FINEENABLE.
- Coarse dec with COARSE_TAP=0 -> no COARSEENABLE; DONE with ERR=1 two cycles after accept.
- Load 9'h02A, then read with COUNTERREADVAL driven 9'h02A -> COUNTERLOADEN pulse carrying 02A; FINE_TAP=42; COUNTERREADEN pulse; RSP_DATA=9'h02A; read DONE 5 cycles after accept.
- Coarse inc with CMD_COUNT=5; COARSEOVERFLOW pulsed during the second SETTLE -> exactly 2 COARSEENABLE pulses, COARSE_TAP=2, DONE with ERR=1.
- RST asserted during SETTLE of a 10-step fine command -> outputs return to 0 and FINE_TAP=0 asynchronously; no DONE; CMD_VALID held high with CMD_COUNT=1 -> command accepted 1 cycle after release.
